wb_copy_master: RTL and testbench

Wishbone classic-cycle initiator that copies a block of 32-bit words from a source address range to a destination address range. It issues single reads and single writes and is the bus-master counterpart of the boot ROM and RAM responders. Typical use is staging boot code from ROM into RAM before the CPU is released from reset. It is driven by a simple start/done command port from the reset and boot controller.

---
 rtl/wb_copy_master.sv | 202 ++++++++++++++++++++
 tb/tb_wb_copy_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_copy_master.sv
// wb_copy_master: Wishbone classic-cycle initiator that copies len_i 32-bit words
// from src_adr_i to dst_adr_i using one single read and one single write per word.
// Optional feature: define WB_COPY_MASTER_TIMEOUT_EN to abort a phase that sees
// no ack/err for 2^TO_W-1 cycles (treated exactly like a responder error).
module wb_copy_master #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int LW   = 16,
    parameter int TO_W = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          start_i,
    input  logic [AW-1:0] src_adr_i,
    input  logic [AW-1:0] dst_adr_i,
    input  logic [LW-1:0] len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW-1:0] wbm_adr_o,
    output logic [DW-1:0] wbm_dat_o,
    input  logic [DW-1:0] wbm_dat_i,
    output logic [3:0]    wbm_sel_o,
    output logic          wbm_we_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i
);

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          to_fire;
    logic          bus_fault;
    logic          finish;

    // Word-aligned views of the command addresses; the low two bits are don't-care.
    logic [AW-1:0] src_al, dst_al;
    assign src_al = {src_adr_i[AW-1:2], 2'b00};
    assign dst_al = {dst_adr_i[AW-1:2], 2'b00};

`ifdef WB_COPY_MASTER_TIMEOUT_EN
    // Fires on the edge where the idle counter would reach its all-ones value.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    logic [TO_W-1:0] to_q, to_d;
    logic            in_phase;

    assign in_phase = (state_q == RD) || (state_q == WR);
    assign to_fire  = in_phase && !wbm_ack_i && !wbm_err_i && (to_q == TO_LAST);

    // Count responder-silent cycles of the current phase; any other cycle restarts it.
    always_comb begin
        to_d = '0;
        if (in_phase && !wbm_ack_i && !wbm_err_i) to_d = to_q + 1'b1;
    end

    // Idle counter register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) to_q <= '0;
        else          to_q <= to_d;
    end
`else
    assign to_fire = 1'b0;
`endif

    // An error response outranks an ack that arrives with it.
    assign bus_fault = wbm_err_i || to_fire;

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start_i) begin
                    src_d  = src_al;
                    dst_d  = dst_al;
                    cnt_d  = len_i;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    if (len_i == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = 1'b0;
                        adr_d   = src_al;
                    end
                end
            end
            RD: begin
                if (bus_fault) begin
                    err_d  = 1'b1;
                    finish = 1'b1;
                end else if (wbm_ack_i) begin
                    dat_d   = wbm_dat_i;
                    state_d = WR;
                    we_d    = 1'b1;
                    adr_d   = dst_q;
                end
            end
            WR: begin
                if (bus_fault) begin
                    err_d  = 1'b1;
                    finish = 1'b1;
                end else if (wbm_ack_i) begin
                    src_d = src_q + AW'(4);
                    dst_d = dst_q + AW'(4);
                    cnt_d = cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) begin
                        finish = 1'b1;
                    end else begin
                        state_d = RD;
                        we_d    = 1'b0;
                        adr_d   = src_q + AW'(4);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Common exit from a bus phase: release the bus and pulse done.
        if (finish) begin
            state_d = FIN;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            done_d  = 1'b1;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = 4'hF;
    assign wbm_we_o  = we_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_wb_copy_master.sv
// Bench for wb_copy_master: memory-backed Wishbone responder with programmable
// wait states / error injection, and a sequential copy model for expectations.
module tb_wb_copy_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] src_i = '0, dst_i = '0;
    logic [15:0] len_i = '0;
    logic        busy, done, err, we, cyc, stb;
    logic [31:0] adr, dat_o;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel;
    logic        ack = 1'b0, berr = 1'b0;

    always #5 clk = ~clk;

    wb_copy_master #(.TO_W(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i),
        .src_adr_i(src_i), .dst_adr_i(dst_i), .len_i(len_i),
        .busy_o(busy), .done_o(done), .err_o(err),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_sel_o(sel),
        .wbm_we_o(we), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
        .wbm_ack_i(ack), .wbm_err_i(berr)
    );

    typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} tx_t;

    logic [31:0] mem  [logic [31:0]];
    logic [31:0] snap [logic [31:0]];
    tx_t         txq[$];
    tx_t         expq[$];
    int          wait_st = 1;
    bit          resp_en = 1'b1;
    bit          err_en = 1'b0;
    logic [31:0] err_adr = '0;
    int          wcnt = 0;
    bit          cyc_seen = 1'b0;
    int          chk_cnt = 0, pass_cnt = 0;

    // Unwritten locations read back as an address-derived pattern.
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    // Responder outputs settle mid-cycle from the master's registered outputs.
    always @(negedge clk) begin
        dat_i = rd_word(adr);
        berr  = !rst && cyc && stb && err_en && we && (adr == err_adr) && (wcnt == wait_st);
        ack   = !rst && resp_en && cyc && stb && !berr && (wcnt == wait_st);
    end

    // Wait-state counter, bus transaction log and memory writes.
    always @(posedge clk) begin
        if (cyc) cyc_seen = 1'b1;
        if (cyc && stb && !(ack || berr)) wcnt <= wcnt + 1;
        else                              wcnt <= 0;
        if (!rst && cyc && stb && ack) begin
            txq.push_back({we, adr, we ? dat_o : dat_i});
            if (we) mem[adr] = dat_o;
        end
    end

    // Reference: copy executes word by word, each read seeing earlier writes.
    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] rs, rd, v;
        rs = {s[31:2], 2'b00};
        rd = {d[31:2], 2'b00};
        expq.delete();
        for (int i = 0; i < n; i++) begin
            v = snap.exists(rs) ? snap[rs] : (rs ^ 32'hC0DE_0000);
            expq.push_back({1'b0, rs, v});
            snap[rd] = v;
            expq.push_back({1'b1, rd, v});
            rs = rs + 32'd4;
            rd = rd + 32'd4;
        end
    endtask

    // Issue one command and return the cycle (after E0) in which done is seen, 0 if never.
    task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                           input int w, input int poke, input int budget, output int dc);
        wait_st = w;
        txq.delete();
        @(negedge clk);
        src_i = s; dst_i = d; len_i = n; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        dc = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (done) begin dc = k; break; end
            if (k == poke) begin
                start_i = 1'b1; src_i = 32'h0BAD_0000; dst_i = 32'h0BAD_1000; len_i = 16'd1;
            end else start_i = 1'b0;
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++; if ({cyc, stb, we, busy, done, err} !== 6'b0) $display("FAIL reset_ctl got %b want 000000", {cyc, stb, we, busy, done, err}); else pass_cnt++;
        chk_cnt++; if (adr !== 32'h0 || dat_o !== 32'h0) $display("FAIL reset_bus adr=%h dat=%h want 0", adr, dat_o); else pass_cnt++;
        chk_cnt++; if (sel !== 4'hF) $display("FAIL reset_sel got %h want f", sel); else pass_cnt++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++; if (cyc !== 1'b0 || busy !== 1'b0) $display("FAIL idle cyc=%b busy=%b want 0", cyc, busy); else pass_cnt++;
    endtask

    task automatic test_normal;
        int dc;
        for (int i = 0; i < 4; i++) begin
            mem[32'(4 * i)] = 32'(8'h11 * (i + 1));
            mem.delete(32'h1000 + 32'(4 * i));
        end
        snap = mem;
        model_copy(32'h0, 32'h1000, 4);
        do_copy(32'h0, 32'h1000, 16'd4, 1, 0, 200, dc);
        chk_cnt++; if (dc !== 17) $display("FAIL normal_done cycle got %0d want 17", dc); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0 || busy !== 1'b1) $display("FAIL normal_flags err=%b busy=%b want 0/1", err, busy); else pass_cnt++;
        chk_cnt++; if (txq.size() != 8) $display("FAIL normal_txcount got %0d want 8", txq.size()); else pass_cnt++;
        for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
            chk_cnt++;
            if (txq[i] !== expq[i]) $display("FAIL normal_tx[%0d] got %b/%h/%h want %b/%h/%h", i, txq[i].w, txq[i].a, txq[i].d, expq[i].w, expq[i].a, expq[i].d);
            else pass_cnt++;
        end
        @(negedge clk);
        chk_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL normal_after done=%b busy=%b want 0/0", done, busy); else pass_cnt++;
    endtask

    task automatic test_random;
        int dc, n, w;
        logic [31:0] s, d;
        for (int it = 0; it < 8; it++) begin
            s = $urandom; d = $urandom;
            n = $urandom_range(1, 5); w = $urandom_range(0, 2);
            if (it == 0) d = s;
            snap = mem;
            model_copy(s, d, n);
            do_copy(s, d, 16'(n), w, 0, 400, dc);
            chk_cnt++; if (dc !== 2 * n * (1 + w) + 1) $display("FAIL rand%0d_done got %0d want %0d", it, dc, 2 * n * (1 + w) + 1); else pass_cnt++;
            chk_cnt++; if (txq.size() != expq.size()) $display("FAIL rand%0d_txcount got %0d want %0d", it, txq.size(), expq.size()); else pass_cnt++;
            for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
                chk_cnt++;
                if (txq[i] !== expq[i]) $display("FAIL rand%0d_tx[%0d] got %b/%h/%h want %b/%h/%h", it, i, txq[i].w, txq[i].a, txq[i].d, expq[i].w, expq[i].a, expq[i].d);
                else pass_cnt++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_len;
        @(negedge clk);
        cyc_seen = 1'b0;
        src_i = 32'h40; dst_i = 32'h80; len_i = 16'd0; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({done, busy, cyc} !== 3'b110) $display("FAIL zero_c1 done/busy/cyc got %b want 110", {done, busy, cyc}); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if ({done, busy} !== 2'b00) $display("FAIL zero_c2 done/busy got %b want 00", {done, busy}); else pass_cnt++;
        repeat (2) @(negedge clk);
        chk_cnt++; if (cyc_seen !== 1'b0) $display("FAIL zero_bus cyc_seen got %b want 0", cyc_seen); else pass_cnt++;
    endtask

    task automatic test_bus_error;
        int dc;
        logic [31:0] v0;
        mem.delete(32'h1000); mem.delete(32'h1004); mem.delete(32'h1008);
        v0 = rd_word(32'h0);
        err_en = 1'b1; err_adr = 32'h1004;
        do_copy(32'h0, 32'h1000, 16'd3, 1, 0, 200, dc);
        chk_cnt++; if (dc !== 9) $display("FAIL buserr_done got %0d want 9", dc); else pass_cnt++;
        chk_cnt++; if ({err, cyc, stb} !== 3'b100) $display("FAIL buserr_flags err/cyc/stb got %b want 100", {err, cyc, stb}); else pass_cnt++;
        chk_cnt++; if (txq.size() != 3) $display("FAIL buserr_txcount got %0d want 3", txq.size()); else pass_cnt++;
        chk_cnt++; if (mem.exists(32'h1004) || mem.exists(32'h1008)) $display("FAIL buserr_extra_write got written want untouched"); else pass_cnt++;
        chk_cnt++; if (!mem.exists(32'h1000) || mem[32'h1000] !== v0) $display("FAIL buserr_word0 got %h want %h", rd_word(32'h1000), v0); else pass_cnt++;
        err_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if ({done, err} !== 2'b01) $display("FAIL buserr_sticky done/err got %b want 01", {done, err}); else pass_cnt++;
        src_i = 32'h0; len_i = 16'd0; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        @(negedge clk);
        chk_cnt++; if (err !== 1'b0) $display("FAIL buserr_clear got %b want 0", err); else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back_wrap;
        int dc;
        snap = mem;
        model_copy(32'hFFFF_FFFB, 32'h2000, 3);
        do_copy(32'hFFFF_FFFB, 32'h2002, 16'd3, 0, 2, 200, dc);
        chk_cnt++; if (dc !== 7) $display("FAIL wrap_done got %0d want 7", dc); else pass_cnt++;
        chk_cnt++; if (txq.size() != 6) $display("FAIL wrap_txcount got %0d want 6", txq.size()); else pass_cnt++;
        if (txq.size() == 6) begin
            chk_cnt++;
            if (txq[0].a !== 32'hFFFF_FFF8 || txq[2].a !== 32'hFFFF_FFFC || txq[4].a !== 32'h0)
                $display("FAIL wrap_rdadr got %h %h %h want fffffff8 fffffffc 00000000", txq[0].a, txq[2].a, txq[4].a);
            else pass_cnt++;
            for (int i = 0; i < 6; i++) begin
                chk_cnt++;
                if (txq[i] !== expq[i]) $display("FAIL wrap_tx[%0d] got %b/%h/%h want %b/%h/%h", i, txq[i].w, txq[i].a, txq[i].d, expq[i].w, expq[i].a, expq[i].d);
                else pass_cnt++;
            end
        end
        cyc_seen = 1'b0;
        repeat (5) @(negedge clk);
        chk_cnt++; if (cyc_seen !== 1'b0) $display("FAIL wrap_poke_ignored cyc_seen got %b want 0", cyc_seen); else pass_cnt++;
    endtask

    task automatic test_reset_midcopy;
        bit seen_wr, seen_done;
        wait_st = 1;
        @(negedge clk);
        src_i = 32'h100; dst_i = 32'h3000; len_i = 16'd4; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        seen_wr = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (we) begin seen_wr = 1'b1; break; end
        end
        chk_cnt++; if (!seen_wr) $display("FAIL rstmid_reach_wr got no write phase want one"); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        chk_cnt++; if ({cyc, stb, we, busy} !== 4'b0) $display("FAIL rstmid_async cyc/stb/we/busy got %b want 0000", {cyc, stb, we, busy}); else pass_cnt++;
        seen_done = 1'b0;
        repeat (3) begin @(negedge clk); if (done) seen_done = 1'b1; end
        rst = 1'b0;
        repeat (3) begin @(negedge clk); if (done) seen_done = 1'b1; end
        chk_cnt++; if (seen_done || busy !== 1'b0) $display("FAIL rstmid_nodone done_seen=%b busy=%b want 0/0", seen_done, busy); else pass_cnt++;
    endtask

    task automatic test_no_ack;
        resp_en = 1'b0;
`ifdef WB_COPY_MASTER_TIMEOUT_EN
        begin
            int dc;
            do_copy(32'h0, 32'h4000, 16'd1, 0, 0, 40, dc);
            chk_cnt++; if (dc !== 16) $display("FAIL timeout_done got %0d want 16", dc); else pass_cnt++;
            chk_cnt++; if ({err, cyc} !== 2'b10) $display("FAIL timeout_flags err/cyc got %b want 10", {err, cyc}); else pass_cnt++;
            @(negedge clk);
            chk_cnt++; if (done !== 1'b0) $display("FAIL timeout_pulse got %b want 0", done); else pass_cnt++;
        end
`else
        begin
            int hi;
            @(negedge clk);
            src_i = 32'h0; dst_i = 32'h4000; len_i = 16'd1; start_i = 1'b1;
            @(posedge clk);
            #1 start_i = 1'b0;
            hi = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (cyc && !done) hi++;
            end
            chk_cnt++; if (hi !== 100) $display("FAIL noack_wait cyc-high cycles got %0d want 100", hi); else pass_cnt++;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
        end
`endif
        resp_en = 1'b1;
    endtask

    initial begin
        test_reset;
        test_normal;
        test_random;
        test_zero_len;
        test_bus_error;
        test_back_to_back_wrap;
        test_reset_midcopy;
        test_no_ack;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
